// File: rtl/slave.sv
// Bit-serial bus memory slave: 3-bit start pattern, then ID/RW/B/ADDR header,
// followed by serial write data on wD or serial read data on rD (single or burst).
module slave #(
  parameter int ADDR_DEPTH = 2000,
  parameter int SLAVES     = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [$clog2(SLAVES)-1:0]  slave_ID,
  input  logic                       control,
  input  logic                       wD,
  input  logic                       valid,
  input  logic                       last,
  output logic                       rD,
  output logic                       ready
);

  localparam int AW  = $clog2(ADDR_DEPTH);
  localparam int IW  = $clog2(SLAVES);
  localparam int HW  = IW + 2 + AW;
  localparam int HCW = $clog2(HW);
  localparam int BCW = $clog2(DATA_WIDTH);

  localparam logic [AW:0]      DEPTH_W   = (AW+1)'(ADDR_DEPTH);
  localparam logic [AW-1:0]    DEPTH_A   = AW'(ADDR_DEPTH);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(ADDR_DEPTH - 1);
  localparam logic [HCW-1:0]   HDR_LAST  = HCW'(HW - 1);
  localparam logic [BCW-1:0]   BIT_LAST  = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, HDR, WRITE, RD_FETCH, RD_SEND} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            start_cnt_reg, start_cnt_next;
  logic [HW-2:0]         hdr_reg, hdr_next;
  logic [HCW-1:0]        hdr_cnt_reg, hdr_cnt_next;
  logic [AW-1:0]         addr_reg, addr_next;
  logic                  burst_reg, burst_next;
  logic [DATA_WIDTH-1:0] word_reg, word_next;
  logic [BCW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic                  rd_reg, rd_next;
  logic                  ready_reg, ready_next;

  logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [HW-1:0]         hdr_full;
  logic [IW-1:0]         hdr_id;
  logic                  hdr_rw;
  logic                  hdr_burst;
  logic [AW-1:0]         hdr_addr_raw;
  logic [AW-1:0]         hdr_addr;
  logic [AW-1:0]         addr_inc;

  assign hdr_full     = {hdr_reg, control};
  assign hdr_id       = hdr_full[HW-1 -: IW];
  assign hdr_rw       = hdr_full[AW+1];
  assign hdr_burst    = hdr_full[AW];
  assign hdr_addr_raw = hdr_full[AW-1:0];
  // The AW-bit field can exceed the depth by less than one depth, so one subtraction folds it.
  assign hdr_addr     = ({1'b0, hdr_addr_raw} >= DEPTH_W) ? hdr_addr_raw - DEPTH_A : hdr_addr_raw;
  assign addr_inc     = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
  assign mem_wdata    = {word_reg[DATA_WIDTH-2:0], wD};

  assign rD    = rd_reg;
  assign ready = ready_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      start_cnt_reg <= '0;
      hdr_reg       <= '0;
      hdr_cnt_reg   <= '0;
      addr_reg      <= '0;
      burst_reg     <= 1'b0;
      word_reg      <= '0;
      bit_cnt_reg   <= '0;
      rd_reg        <= 1'b0;
      ready_reg     <= 1'b1;
    end else begin
      state_reg     <= state_next;
      start_cnt_reg <= start_cnt_next;
      hdr_reg       <= hdr_next;
      hdr_cnt_reg   <= hdr_cnt_next;
      addr_reg      <= addr_next;
      burst_reg     <= burst_next;
      word_reg      <= word_next;
      bit_cnt_reg   <= bit_cnt_next;
      rd_reg        <= rd_next;
      ready_reg     <= ready_next;
    end
  end

  // Read uses the next address so the word is already waiting during RD_FETCH.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_reg] <= mem_wdata;
    rdata_reg <= mem[addr_next];
  end

  always_comb begin
    state_next     = state_reg;
    start_cnt_next = start_cnt_reg;
    hdr_next       = hdr_reg;
    hdr_cnt_next   = hdr_cnt_reg;
    addr_next      = addr_reg;
    burst_next     = burst_reg;
    word_next      = word_reg;
    bit_cnt_next   = bit_cnt_reg;
    rd_next        = 1'b0;
    mem_we         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!control) begin
          start_cnt_next = '0;
        end else if (start_cnt_reg == 2'd2) begin
          start_cnt_next = '0;
          hdr_cnt_next   = '0;
          state_next     = HDR;
        end else begin
          start_cnt_next = start_cnt_reg + 2'd1;
        end
      end

      HDR: begin
        hdr_next = hdr_full[HW-2:0];
        if (hdr_cnt_reg == HDR_LAST) begin
          hdr_cnt_next = '0;
          bit_cnt_next = '0;
          if (hdr_id != slave_ID) begin
            state_next = IDLE;
          end else begin
            addr_next  = hdr_addr;
            burst_next = hdr_burst;
            state_next = hdr_rw ? WRITE : RD_FETCH;
          end
        end else begin
          hdr_cnt_next = hdr_cnt_reg + 1'b1;
        end
      end

      WRITE: begin
        if (valid) begin
          word_next = mem_wdata;
          if (bit_cnt_reg == BIT_LAST) begin
            mem_we       = 1'b1;
            bit_cnt_next = '0;
            if (burst_reg) addr_next  = addr_inc;
            else           state_next = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        // A completing word is already committed above; only partial bits are dropped.
        if (burst_reg && last) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end
      end

      RD_FETCH: begin
        word_next    = rdata_reg;
        rd_next      = rdata_reg[DATA_WIDTH-1];
        bit_cnt_next = '0;
        state_next   = RD_SEND;
        if (burst_reg && last) begin
          rd_next    = 1'b0;
          state_next = IDLE;
        end
      end

      RD_SEND: begin
        if (bit_cnt_reg == BIT_LAST) begin
          bit_cnt_next = '0;
          if (burst_reg) begin
            addr_next  = addr_inc;
            state_next = RD_FETCH;
          end else begin
            state_next = IDLE;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          word_next    = word_reg << 1;
          rd_next      = word_reg[DATA_WIDTH-2];
        end
        if (burst_reg && last) begin
          rd_next      = 1'b0;
          bit_cnt_next = '0;
          state_next   = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    ready_next = (state_next != RD_FETCH);
  end

endmodule

// File: tb/tb_slave.sv
// Randomized bench for the serial memory slave, checked against a plain array
// model of the RAM and the header/serial timing rules.
module tb_slave;
  localparam int ADDR_DEPTH = 2000;
  localparam int SLAVES     = 3;
  localparam int DATA_WIDTH = 8;
  localparam int AW         = $clog2(ADDR_DEPTH);
  localparam int IW         = $clog2(SLAVES);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [IW-1:0] slave_id = 2'b01;
  logic          control = 1'b0;
  logic          wd = 1'b0;
  logic          valid = 1'b0;
  logic          last = 1'b0;
  logic          rd;
  logic          ready;

  int n_cmp = 0;
  int n_err = 0;
  // -1 marks a word never written, whose read-back is not predicted.
  int ref_mem [ADDR_DEPTH];

  slave #(.ADDR_DEPTH(ADDR_DEPTH), .SLAVES(SLAVES), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .resetn(resetn), .slave_ID(slave_id), .control(control),
    .wD(wd), .valid(valid), .last(last), .rD(rd), .ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_rd"}, rd, 0);
      check({tag, "_ready"}, ready, 1);
      step();
    end
  endtask

  task automatic send_header(input logic [IW-1:0] id, input logic rw, input logic b,
                             input logic [AW-1:0] addr);
    logic [IW+AW+4:0] h;
    h = {3'b111, id, rw, b, addr};
    for (int i = IW + AW + 4; i >= 0; i--) begin
      control = h[i];
      step();
    end
    control = 1'b0;
  endtask

  task automatic write_txn(input logic [IW-1:0] id, input logic [AW-1:0] haddr, input bit burst,
                           input int nwords, input int fixed_word, input int word_gap,
                           input int bit_gap_max, input int partial, input bit last_on_final,
                           input bit ctl_high);
    bit hit;
    int a;
    logic [DATA_WIDTH-1:0] word;
    hit = (id == slave_id);
    a = int'(haddr) % ADDR_DEPTH;
    $display("txn WRITE id=%0d addr=%0d burst=%0d words=%0d hit=%0d", id, haddr, burst, nwords, hit);
    send_header(id, 1'b1, burst, haddr);
    if (ctl_high) control = 1'b1;
    for (int w = 0; w < nwords; w++) begin
      word = (fixed_word >= 0) ? DATA_WIDTH'(fixed_word) : DATA_WIDTH'($urandom);
      for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
        repeat ($urandom_range(0, bit_gap_max)) begin
          valid = 1'b0;
          wd = 1'($urandom);
          step();
          check("wr_ready_gap", ready, 1);
        end
        valid = 1'b1;
        wd = word[b];
        if (burst && last_on_final && w == nwords - 1 && b == 0) last = 1'b1;
        step();
        last = 1'b0;
        valid = 1'b0;
        check("wr_ready", ready, 1);
        check("wr_rd", rd, 0);
      end
      if (hit) begin
        ref_mem[a] = int'(word);
        a = (a + 1) % ADDR_DEPTH;
      end
      if (w == nwords - 1) control = 1'b0;
      repeat (word_gap) begin
        wd = 1'($urandom);
        step();
        check("wr_ready_word_gap", ready, 1);
      end
    end
    control = 1'b0;
    if (burst && !last_on_final) begin
      for (int p = 0; p < partial; p++) begin
        valid = 1'b1;
        wd = 1'($urandom);
        step();
      end
      valid = 1'b0;
      last = 1'b1;
      step();
      last = 1'b0;
    end
    check_idle("wr_end", 2);
  endtask

  // Burst reads take nwords full words, then stop_bits bits of one more word before last.
  task automatic read_txn(input logic [IW-1:0] id, input logic [AW-1:0] haddr, input bit burst,
                          input int nwords, input int stop_bits);
    bit hit;
    bit stopped;
    int a;
    int exp;
    hit = (id == slave_id);
    a = int'(haddr) % ADDR_DEPTH;
    stopped = 1'b0;
    $display("txn READ  id=%0d addr=%0d burst=%0d words=%0d stop=%0d hit=%0d",
             id, haddr, burst, nwords, stop_bits, hit);
    send_header(id, 1'b0, burst, haddr);
    if (!hit) begin
      check_idle("rd_miss", 12);
      return;
    end
    for (int w = 0; !stopped; w++) begin
      check("fetch_ready", ready, 0);
      check("fetch_rd", rd, 0);
      if (burst && w == nwords && stop_bits == 0) begin
        last = 1'b1;
        step();
        last = 1'b0;
        break;
      end
      step();
      exp = ref_mem[a];
      for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
        if (exp >= 0) check($sformatf("rd_bit%0d_a%0d", b, a), rd, exp[b]);
        check("send_ready", ready, 1);
        if (burst && w == nwords && (DATA_WIDTH - 1 - b) == stop_bits - 1) begin
          last = 1'b1;
          step();
          last = 1'b0;
          stopped = 1'b1;
          break;
        end
        step();
      end
      if (!burst) break;
      a = (a + 1) % ADDR_DEPTH;
    end
    check_idle("rd_end", 2);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 15));
    return AW'($urandom_range(1990, 2015));
  endfunction

  initial begin
    for (int i = 0; i < ADDR_DEPTH; i++) ref_mem[i] = -1;

    #12;
    check("reset_rd", rd, 0);
    check("reset_ready", ready, 1);
    step();
    resetn = 1'b1;
    check_idle("post_reset", 3);

    // Burst write of 0x70 words from address 3, one idle cycle between words.
    write_txn(2'b01, 11'd3, 1'b1, 4, 'h70, 1, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a burst read, then read the same words back.
    $display("txn READ  burst from 3 interrupted by reset");
    send_header(2'b01, 1'b0, 1'b1, 11'd3);
    check("pre_fetch_ready", ready, 0);
    repeat (4) step();
    check("pre_reset_rd", rd, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_rd", rd, 0);
    check("async_reset_ready", ready, 1);
    step();
    step();
    resetn = 1'b1;
    check_idle("after_mid_reset", 3);
    read_txn(2'b01, 11'd3, 1'b1, 3, 3);

    // Single write of 0xFF to address 0 with control held high behind the header.
    write_txn(2'b01, 11'd0, 1'b0, 1, 'hFF, 0, 0, 0, 1'b0, 1'b1);
    check_idle("trailing_ctl", 20);

    read_txn(2'b01, 11'd0, 1'b0, 1, 0);
    read_txn(2'b01, 11'd3, 1'b0, 1, 0);

    // Foreign-ID traffic must leave memory and outputs untouched.
    write_txn(2'b10, 11'd0, 1'b0, 1, 'h00, 0, 0, 0, 1'b0, 1'b0);
    read_txn(2'b10, 11'd3, 1'b0, 1, 0);
    read_txn(2'b01, 11'd0, 1'b0, 1, 0);

    // Burst write across the top of memory; the second word wraps to address 0.
    write_txn(2'b01, 11'd1999, 1'b1, 2, -1, 0, 0, 0, 1'b1, 1'b0);
    read_txn(2'b01, 11'd1999, 1'b1, 2, 0);

    // Header address above the depth folds back (2003 -> 3).
    write_txn(2'b01, 11'd2003, 1'b0, 1, 'hA5, 0, 0, 0, 1'b0, 1'b0);
    read_txn(2'b01, 11'd3, 1'b0, 1, 0);

    // Fill the random pool, then mix random transactions.
    write_txn(2'b01, 11'd0, 1'b1, 16, -1, 0, 0, 3, 1'b0, 1'b0);
    write_txn(2'b01, 11'd1990, 1'b1, 10, -1, 0, 1, 0, 1'b1, 1'b0);
    for (int t = 0; t < 40; t++) begin
      logic [IW-1:0] id;
      logic [AW-1:0] addr;
      int op;
      op = int'($urandom_range(0, 3));
      addr = pick_addr();
      id = ($urandom_range(0, 5) == 0) ? 2'b10 : slave_id;
      if ($urandom_range(0, 3) == 0) begin
        control = 1'b1;
        step();
        step();
        control = 1'b0;
        step();
      end
      case (op)
        0: write_txn(id, addr, 1'b0, 1, -1, 0, 2, 0, 1'b0, 1'b0);
        1: write_txn(id, addr, 1'b1, int'($urandom_range(1, 4)), -1, int'($urandom_range(0, 2)),
                     2, int'($urandom_range(0, 7)), 1'($urandom), 1'b0);
        2: read_txn(id, addr, 1'b0, 1, 0);
        default: read_txn(id, addr, 1'b1, int'($urandom_range(1, 3)), int'($urandom_range(0, 7)));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slave.md
Name: slave

Overview:
- Serial-bus memory slave holding an internal ADDR_DEPTH x DATA_WIDTH RAM.
- A master addresses it with an 18-bit serial control header sent on `control` (for the default parameters), then exchanges data bit-serially: write data on `wD`, read data on `rD`.
- Supports single and burst reads and writes. A burst uses an auto-incrementing address and is terminated by `last`.
- Several slaves share one bus; each compares the header ID field against its own `slave_ID` input.

Parameters:
- ADDR_DEPTH, 2000: number of RAM words. Address width AW = $clog2(ADDR_DEPTH), which is 11 for the default.
- SLAVES, 3: number of slaves on the bus. ID width IW = $clog2(SLAVES), which is 2 for the default.
- DATA_WIDTH, 8: bits per word.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- slave_ID  in  IW  this slave's bus ID (static).
- control  in  1  serial header line, sampled every clock edge.
- wD  in  1  serial write data, MSB first.
- valid  in  1  high while `wD` carries a valid write bit.
- last  in  1  master ends the current burst.
- rD  out  1  serial read data, MSB first.
- ready  out  1  slave ready; high by default.

Behaviour:

Reset:
- Async, active low. Outputs: rD=0, ready=1.
- State goes to IDLE and the start-bit counter and all shift registers are cleared.
- RAM contents are NOT cleared; data survives reset.

Header format (MSB first, one bit per clock):
- Fields in order: start `111` | ID[IW-1:0] | RW | B | ADDR[AW-1:0]. Total 18 bits for the defaults.
- RW=1 means write, RW=0 means read. B=1 means burst, B=0 means single word.

States: IDLE, HDR, WRITE, RD_FETCH, RD_SEND.

IDLE:
- Count consecutive `control`=1 samples; any 0 resets the count.
- On the third consecutive 1, go to HDR.

HDR:
- Shift in IW+2+AW bits.
- On the edge sampling the final address bit:
  - If ID != slave_ID: go to IDLE and ignore the transaction.
  - Else if RW=1: go to WRITE.
  - Else: go to RD_FETCH.
- `control` is ignored from then until the slave returns to IDLE; extra 1s after the header must not restart it.

WRITE:
- On each edge with valid=1, shift `wD` into the word register.
- valid=0 pauses shifting without losing partial bits.
- When DATA_WIDTH bits have been received: write mem[addr] on that same edge and reset the bit count.
  - Burst: addr increments.
  - Single: go to IDLE.
- Burst write: last=1 on any edge goes to IDLE. A partial word is discarded; a word completing on that same edge is still written.
- ready=1 throughout.

RD_FETCH:
- One cycle with ready=0; the word register loads mem[addr].
- Next state is RD_SEND.

RD_SEND:
- Lasts DATA_WIDTH cycles; rD presents the word MSB first, one bit per cycle, registered; ready=1.
- After the last bit:
  - Single read: go to IDLE.
  - Burst read: addr increments and the slave returns to RD_FETCH (one-cycle gap with ready=0).
- Burst read: last=1 on any edge in RD_FETCH/RD_SEND goes to IDLE.

rD and addressing rules:
- rD=0 in every state other than RD_SEND.
- Address wrap: after ADDR_DEPTH-1 the address goes to 0.
- A header address >= ADDR_DEPTH is reduced modulo ADDR_DEPTH.

Timing:
- Write: the first data bit can be sampled on the edge after the final header bit.
- Read: the first rD bit appears 2 cycles after the final header bit.

Test Plan:
1. Reset, slave_ID=01, then header 111_01_11_00000000011 (burst write from addr 3). Send words 0x70, 0x70, ... with valid held low 1 cycle between words, then last=1 -> mem[3..] hold 0x70 and ready stays 1.
2. Pulse resetn low mid-operation, then header 111_01_01_00000000011 (burst read) -> ready low 1 cycle, rD shows 0x70 MSB first per word, repeating. Raise last -> IDLE, rD=0. Confirms RAM survives reset.
3. Header 111_01_10_00000000000 (single write), wD=1 with valid=1 for 8 cycles -> mem[0]=0xFF, then IDLE. Trailing 1s on control after the header start no new transaction.
4. Header 111_01_00_00000000000 (single read) -> rD=1 for 8 cycles (0xFF), then 0. Header 111_01_00_00000000011 -> rD serializes 0x70.
5. Header with ID=10 while slave_ID=01 -> no write, rD stays 0, ready stays 1; the next valid header is accepted normally.
6. Burst write starting at addr 1999 for 2 words -> the second word lands at addr 0.
